// File: rtl/spi_host_ctrl_if.sv
// Command/data handshake bundle for the SPI register-slave initiator.
//   master : client side (issues commands, supplies write bytes, takes read bytes)
//   slave  : controller side (spi_host_ctrl)
// Signals: cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_len, tx_valid/tx_ready/tx_data,
//          rx_valid/rx_data, busy, done.
interface spi_host_ctrl_if #(
  parameter int unsigned LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic [6:0]       cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             tx_valid;
  logic             tx_ready;
  logic [7:0]       tx_data;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, tx_valid, tx_data,
    input  cmd_ready, tx_ready, rx_valid, rx_data, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, tx_valid, tx_data,
    output cmd_ready, tx_ready, rx_valid, rx_data, busy, done
  );
endinterface

// File: rtl/spi_host_ctrl.sv
// SPI mode-0 initiator for the on-chip SPI register slave (test / bring-up path).
// Frame: {is_write, addr[6:0]} then cmd_len data bytes, MSB first; cs is active high.
// Ports:
//   clk, rstn      system clock, async active-low reset
//   bus (slave)    command, write-byte stream, read-byte return, busy/done
//   loopback       (only with SPI_HOST_LOOPBACK_EN) sample mosi instead of miso
//   sclk, cs, mosi SPI outputs (idle 0)
//   miso           SPI input, sampled on sclk rising edges
// Optional feature macro: SPI_HOST_LOOPBACK_EN.
module spi_host_ctrl #(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned LEN_W   = 8
) (
  input  logic            clk,
  input  logic            rstn,
  spi_host_ctrl_if.slave  bus,
`ifdef SPI_HOST_LOOPBACK_EN
  input  logic            loopback,
`endif
  output logic            sclk,
  output logic            cs,
  output logic            mosi,
  input  logic            miso
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HP_W  = 4;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, LOAD, HOLD} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [HP_W-1:0]  hp_cnt;
  logic [7:0]       shreg;
  logic [7:0]       rx_shreg;
  logic [7:0]       nxt_byte;
  logic             have_nxt;
  logic [LEN_W-1:0] bytes_left;
  logic             is_wr;
  logic             is_addr;
  logic             cmd_ready_q;
  logic             tx_ready_q;
  logic             rx_valid_q;
  logic [7:0]       rx_data_q;
  logic             busy_q;
  logic             done_q;

  logic tick_c;
  logic more_c;
  logic take_c;
  logic sample_c;

  assign tick_c = (div_cnt == DIV_W'(CLK_DIV - 1));
  // Another data byte follows the byte currently on the wire.
  assign more_c = is_addr ? (bytes_left != '0) : (bytes_left != LEN_W'(1));
  assign take_c = tx_ready_q & bus.tx_valid;

`ifdef SPI_HOST_LOOPBACK_EN
  assign sample_c = loopback ? mosi : miso;
`else
  assign sample_c = miso;
`endif

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.tx_ready  = tx_ready_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  // Frame sequencer. The next write byte is fetched during the last sclk-high
  // half of the current byte so a ready stream sees no inter-byte gap; if none
  // has arrived by byte end the engine parks in LOAD with sclk low, cs high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      div_cnt     <= '0;
      hp_cnt      <= '0;
      shreg       <= '0;
      rx_shreg    <= '0;
      nxt_byte    <= '0;
      have_nxt    <= 1'b0;
      bytes_left  <= '0;
      is_wr       <= 1'b0;
      is_addr     <= 1'b0;
      cmd_ready_q <= 1'b1;
      tx_ready_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sclk        <= 1'b0;
      cs          <= 1'b0;
      mosi        <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      div_cnt    <= tick_c ? '0 : div_cnt + DIV_W'(1);

      unique case (state)
        IDLE: begin
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          if (bus.cmd_valid && cmd_ready_q) begin
            is_wr       <= bus.cmd_write;
            is_addr     <= 1'b1;
            bytes_left  <= bus.cmd_len;
            shreg       <= {bus.cmd_write, bus.cmd_addr};
            mosi        <= bus.cmd_write;
            cs          <= 1'b1;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            have_nxt    <= 1'b0;
            div_cnt     <= '0;
            hp_cnt      <= '0;
            state       <= SETUP;
          end
        end

        SETUP: begin
          if (tick_c) begin
            hp_cnt <= '0;
            state  <= SHIFT;
          end
        end

        SHIFT: begin
          if (take_c) begin
            nxt_byte   <= bus.tx_data;
            have_nxt   <= 1'b1;
            tx_ready_q <= 1'b0;
          end
          if (tick_c) begin
            hp_cnt <= hp_cnt + HP_W'(1);
            if (!hp_cnt[0]) begin
              // Rising edge: sample; after the 8th one open the write-byte window.
              sclk     <= 1'b1;
              rx_shreg <= {rx_shreg[6:0], sample_c};
              if (hp_cnt == HP_W'(14) && is_wr && more_c && !have_nxt)
                tx_ready_q <= 1'b1;
            end else begin
              sclk <= 1'b0;
              if (hp_cnt != HP_W'(15)) begin
                shreg <= {shreg[6:0], 1'b0};
                mosi  <= shreg[6];
              end else begin
                // Byte end.
                is_addr <= 1'b0;
                if (!is_addr) begin
                  bytes_left <= bytes_left - LEN_W'(1);
                  if (!is_wr) begin
                    rx_data_q  <= rx_shreg;
                    rx_valid_q <= 1'b1;
                  end
                end
                if (!more_c) begin
                  state <= HOLD;
                end else if (!is_wr) begin
                  shreg <= 8'h00;
                  mosi  <= 1'b0;
                end else if (have_nxt) begin
                  shreg    <= nxt_byte;
                  mosi     <= nxt_byte[7];
                  have_nxt <= 1'b0;
                end else if (take_c) begin
                  shreg    <= bus.tx_data;
                  mosi     <= bus.tx_data[7];
                  have_nxt <= 1'b0;
                end else begin
                  state <= LOAD;
                end
              end
            end
          end
        end

        LOAD: begin
          if (take_c) begin
            shreg      <= bus.tx_data;
            mosi       <= bus.tx_data[7];
            tx_ready_q <= 1'b0;
            div_cnt    <= '0;
            state      <= SETUP;
          end
        end

        HOLD: begin
          if (tick_c) begin
            cs     <= 1'b0;
            sclk   <= 1'b0;
            mosi   <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_host_ctrl.sv
// Directed bench for spi_host_ctrl with a behavioural mode-0 register slave.
module tb_spi_host_ctrl;
  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned LEN_W   = 8;

  logic clk = 1'b0;
  logic rstn;
  logic sclk, cs, mosi, miso;
`ifdef SPI_HOST_LOOPBACK_EN
  logic loopback;
`endif

  spi_host_ctrl_if #(.LEN_W(LEN_W)) bus ();

  spi_host_ctrl #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
`ifdef SPI_HOST_LOOPBACK_EN
    .loopback (loopback),
`endif
    .sclk     (sclk),
    .cs       (cs),
    .mosi     (mosi),
    .miso     (miso)
  );

  always #5 clk = ~clk;

  int chk  = 0;
  int pass = 0;

  // ---------------- slave model ----------------
  logic [7:0] sl_bytes [4];
  logic [7:0] mosi_q [$];
  logic [7:0] sl_sh;
  logic       s_miso = 1'b0;
  int         rcnt   = 0;

  assign miso = s_miso;

  function automatic logic [7:0] sl_byte_at(input int n);
    return (n / 8 < 4) ? sl_bytes[n / 8] : 8'h00;
  endfunction

  always @(posedge cs) begin
    logic [7:0] b;
    rcnt   = 0;
    b      = sl_byte_at(0);
    s_miso = b[7];
  end

  always @(posedge sclk) begin
    sl_sh = {sl_sh[6:0], mosi};
    if (rcnt % 8 == 7) mosi_q.push_back(sl_sh);
    rcnt++;
  end

  always @(negedge sclk) begin
    logic [7:0] b;
    if (cs) begin
      b      = sl_byte_at(rcnt);
      s_miso = b[7 - (rcnt % 8)];
    end
  end

  // ---------------- write-byte source ----------------
  logic [7:0] tx_q [$];
  int  pops       = 0;
  int  stall_at   = 0;
  int  stall_len  = 0;
  int  stall_hold = 0;
  bit  take       = 1'b0;

  always @(negedge clk) take = bus.tx_valid && bus.tx_ready;

  always @(posedge clk) begin
    #1;
    if (take) begin
      if (tx_q.size() != 0) void'(tx_q.pop_front());
      pops++;
      if (pops == stall_at) stall_hold = stall_len;
    end else if (stall_hold > 0) begin
      stall_hold--;
    end
    bus.tx_valid = (tx_q.size() != 0) && (stall_hold == 0);
    bus.tx_data  = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
  end

  // ---------------- monitor ----------------
  int         cs_hi = 0, rise = 0, done_n = 0, done_nobusy = 0, txr_n = 0, stall_bad = 0;
  logic       sclk_prev = 1'b0;
  logic [7:0] rx_q [$];

  always @(negedge clk) begin
    if (cs) cs_hi++;
    if (sclk && !sclk_prev) rise++;
    sclk_prev = sclk;
    if (bus.done) done_n++;
    if (bus.done && !bus.busy) done_nobusy++;
    if (bus.tx_ready) txr_n++;
    if (bus.rx_valid) rx_q.push_back(bus.rx_data);
    if (stall_hold >= 1 && stall_hold <= 6 && (sclk || !cs)) stall_bad++;
  end

  task automatic clear_mon();
    cs_hi = 0; rise = 0; done_n = 0; done_nobusy = 0; txr_n = 0; stall_bad = 0;
    mosi_q.delete(); rx_q.delete(); pops = 0; stall_at = 0; stall_len = 0;
  endtask

  task automatic send_cmd(input logic wr, input logic [6:0] a, input logic [LEN_W-1:0] n);
    @(negedge clk);
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_len   = n;
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    chk++; if (cs !== 1'b0 || sclk !== 1'b0) $display("FAIL reset_spi: cs=%b sclk=%b want 0 0", cs, sclk); else pass++;
    chk++; if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) $display("FAIL reset_hs: cmd_ready=%b busy=%b want 1 0", bus.cmd_ready, bus.busy); else pass++;
    rstn = 1'b1;
    @(negedge clk);
    chk++; if (mosi !== 1'b0 || bus.tx_ready !== 1'b0 || bus.rx_valid !== 1'b0 || bus.done !== 1'b0)
      $display("FAIL reset_out: mosi=%b tx_ready=%b rx_valid=%b done=%b want 0 0 0 0", mosi, bus.tx_ready, bus.rx_valid, bus.done);
    else pass++;
    chk++; if (bus.rx_data !== 8'h00 || bus.cmd_ready !== 1'b1) $display("FAIL reset_rx: rx_data=%h cmd_ready=%b want 00 1", bus.rx_data, bus.cmd_ready); else pass++;
  endtask

  task automatic test_write();
    bit ok;
    clear_mon();
    tx_q = '{8'hA5, 8'h3C};
    send_cmd(1'b1, 7'h05, 8'd2);
    wait_done(ok);
    chk++; if (!ok) $display("FAIL wr_timeout: done=0 want 1"); else pass++;
    @(negedge clk);
    chk++; if (bus.busy !== 1'b0 || bus.cmd_ready !== 1'b1) $display("FAIL wr_after_done: busy=%b cmd_ready=%b want 0 1", bus.busy, bus.cmd_ready); else pass++;
    repeat (6) @(negedge clk);
    chk++; if (mosi_q.size() != 3) $display("FAIL wr_nbytes: got %0d want 3", mosi_q.size()); else pass++;
    chk++; if (mosi_q[0] !== 8'h85 || mosi_q[1] !== 8'hA5 || mosi_q[2] !== 8'h3C)
      $display("FAIL wr_bytes: got %h %h %h want 85 a5 3c", mosi_q[0], mosi_q[1], mosi_q[2]);
    else pass++;
    chk++; if (rise != 24) $display("FAIL wr_rise: got %0d want 24", rise); else pass++;
    chk++; if (cs_hi != 100) $display("FAIL wr_cs_high: got %0d want 100", cs_hi); else pass++;
    chk++; if (done_n != 1 || done_nobusy != 0) $display("FAIL wr_done: pulses=%0d nobusy=%0d want 1 0", done_n, done_nobusy); else pass++;
    chk++; if (rx_q.size() != 0) $display("FAIL wr_no_rx: got %0d want 0", rx_q.size()); else pass++;
  endtask

  task automatic test_read();
    bit ok;
    clear_mon();
    sl_bytes = '{8'hEE, 8'h11, 8'h22, 8'h33};
    send_cmd(1'b0, 7'h10, 8'd3);
    wait_done(ok);
    chk++; if (!ok) $display("FAIL rd_timeout: done=0 want 1"); else pass++;
    repeat (6) @(negedge clk);
    chk++; if (mosi_q.size() != 4 || mosi_q[0] !== 8'h10 || mosi_q[1] !== 8'h00 || mosi_q[2] !== 8'h00 || mosi_q[3] !== 8'h00)
      $display("FAIL rd_mosi: n=%0d got %h %h %h %h want 10 00 00 00", mosi_q.size(), mosi_q[0], mosi_q[1], mosi_q[2], mosi_q[3]);
    else pass++;
    chk++; if (rx_q.size() != 3) $display("FAIL rd_npulse: got %0d want 3", rx_q.size()); else pass++;
    chk++; if (rx_q[0] !== 8'h11 || rx_q[1] !== 8'h22 || rx_q[2] !== 8'h33)
      $display("FAIL rd_data: got %h %h %h want 11 22 33", rx_q[0], rx_q[1], rx_q[2]);
    else pass++;
    chk++; if (bus.rx_data !== 8'h33) $display("FAIL rd_hold: got %h want 33", bus.rx_data); else pass++;
    chk++; if (rise != 32 || cs_hi != 132) $display("FAIL rd_timing: rise=%0d cs_high=%0d want 32 132", rise, cs_hi); else pass++;
    chk++; if (txr_n != 0) $display("FAIL rd_no_txready: got %0d want 0", txr_n); else pass++;
  endtask

  task automatic test_stall();
    bit ok;
    clear_mon();
    stall_at  = 1;
    stall_len = 40;
    tx_q = '{8'hA5, 8'h3C};
    send_cmd(1'b1, 7'h05, 8'd2);
    wait_done(ok);
    chk++; if (!ok) $display("FAIL st_timeout: done=0 want 1"); else pass++;
    repeat (6) @(negedge clk);
    chk++; if (mosi_q.size() != 3 || mosi_q[1] !== 8'hA5 || mosi_q[2] !== 8'h3C)
      $display("FAIL st_bytes: n=%0d got %h %h want a5 3c", mosi_q.size(), mosi_q[1], mosi_q[2]);
    else pass++;
    chk++; if (rise != 24) $display("FAIL st_rise: got %0d want 24", rise); else pass++;
    chk++; if (stall_bad != 0) $display("FAIL st_idle_bus: bad cycles=%0d want 0", stall_bad); else pass++;
    chk++; if (cs_hi <= 100 || done_n != 1) $display("FAIL st_cs: cs_high=%0d done=%0d want >100 1", cs_hi, done_n); else pass++;
  endtask

  task automatic test_len0();
    bit ok;
    clear_mon();
    tx_q = '{8'h5A};
    send_cmd(1'b1, 7'h7F, 8'd0);
    wait_done(ok);
    chk++; if (!ok) $display("FAIL l0_timeout: done=0 want 1"); else pass++;
    repeat (6) @(negedge clk);
    chk++; if (mosi_q.size() != 1 || mosi_q[0] !== 8'hFF) $display("FAIL l0_byte: n=%0d got %h want 1 ff", mosi_q.size(), mosi_q[0]); else pass++;
    chk++; if (txr_n != 0 || rx_q.size() != 0) $display("FAIL l0_quiet: tx_ready=%0d rx=%0d want 0 0", txr_n, rx_q.size()); else pass++;
    chk++; if (done_n != 1 || rise != 8 || cs_hi != 36) $display("FAIL l0_frame: done=%0d rise=%0d cs_high=%0d want 1 8 36", done_n, rise, cs_hi); else pass++;
    tx_q.delete();
  endtask

  task automatic test_miso_ones();
    bit ok;
    clear_mon();
    sl_bytes = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    send_cmd(1'b0, 7'h01, 8'd1);
    wait_done(ok);
    repeat (4) @(negedge clk);
    chk++; if (!ok || rx_q.size() != 1 || rx_q[0] !== 8'hFF) $display("FAIL ones_rx: ok=%0d n=%0d got %h want 1 1 ff", ok, rx_q.size(), rx_q[0]); else pass++;
`ifdef SPI_HOST_LOOPBACK_EN
    clear_mon();
    loopback = 1'b1;
    send_cmd(1'b0, 7'h01, 8'd1);
    wait_done(ok);
    repeat (4) @(negedge clk);
    loopback = 1'b0;
    chk++; if (!ok || rx_q.size() != 1 || rx_q[0] !== 8'h00) $display("FAIL loop_rx: ok=%0d n=%0d got %h want 1 1 00", ok, rx_q.size(), rx_q[0]); else pass++;
    chk++; if (mosi_q.size() != 2 || mosi_q[0] !== 8'h01) $display("FAIL loop_mosi: n=%0d got %h want 2 01", mosi_q.size(), mosi_q[0]); else pass++;
`endif
  endtask

  task automatic test_reset_mid_shift();
    bit hit = 1'b0;
    clear_mon();
    tx_q = '{8'hA5, 8'h3C};
    send_cmd(1'b1, 7'h05, 8'd2);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cs && rcnt >= 3) begin
        hit = 1'b1;
        break;
      end
    end
    chk++; if (!hit) $display("FAIL rst_mid_reach: bit3 not reached"); else pass++;
    rstn = 1'b0;
    @(negedge clk);
    chk++; if (cs !== 1'b0 || sclk !== 1'b0 || bus.busy !== 1'b0) $display("FAIL rst_mid_out: cs=%b sclk=%b busy=%b want 0 0 0", cs, sclk, bus.busy); else pass++;
    tx_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk++; if (bus.cmd_ready !== 1'b1 || bus.tx_ready !== 1'b0) $display("FAIL rst_mid_ready: cmd_ready=%b tx_ready=%b want 1 0", bus.cmd_ready, bus.tx_ready); else pass++;
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    clear_mon();
    send_cmd(1'b0, 7'h01, 8'd0);
    wait_done(ok1);
    send_cmd(1'b0, 7'h02, 8'd0);
    @(negedge clk);
    chk++; if (bus.busy !== 1'b1) $display("FAIL b2b_accept: busy=%b want 1", bus.busy); else pass++;
    wait_done(ok2);
    repeat (4) @(negedge clk);
    chk++; if (!ok1 || !ok2 || done_n != 2) $display("FAIL b2b_done: ok=%0d%0d pulses=%0d want 11 2", ok1, ok2, done_n); else pass++;
    chk++; if (mosi_q.size() != 2 || mosi_q[0] !== 8'h01 || mosi_q[1] !== 8'h02)
      $display("FAIL b2b_bytes: n=%0d got %h %h want 01 02", mosi_q.size(), mosi_q[0], mosi_q[1]);
    else pass++;
  endtask

  initial begin
    rstn          = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.tx_valid  = 1'b0;
    bus.tx_data   = '0;
    sl_bytes      = '{8'h00, 8'h00, 8'h00, 8'h00};
`ifdef SPI_HOST_LOOPBACK_EN
    loopback      = 1'b0;
`endif
    test_reset();
    test_write();
    test_read();
    test_stall();
    test_len0();
    test_miso_ones();
    test_reset_mid_shift();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
